// File: rtl/cc_basics_pkg.sv
// Shared constants for the cc_* building blocks.
// Holds the round-robin encoder state encodings.
package cc_basics_pkg;

    localparam logic CC_RR_IDLE  = 1'b0;
    localparam logic CC_RR_GRANT = 1'b1;

endpackage

// File: rtl/cc_round_robin_encoder_if.sv
// Request/grant bundle of the round-robin encoder.
// master: requesters/consumer (drive req, ack); slave: encoder (drives valid, index, grant).
interface cc_round_robin_encoder_if #(
    parameter int WIDTH = 2
);

    logic [(1<<WIDTH)-1:0] req;
    logic                  ack;
    logic                  valid;
    logic [WIDTH-1:0]      index;
    logic [(1<<WIDTH)-1:0] grant;

    modport master (
        output req, ack,
        input  valid, index, grant
    );

    modport slave (
        input  req, ack,
        output valid, index, grant
    );

endinterface

// File: rtl/CC_Decoder.sv
// Binary to one-hot decoder.
// sel: binary input; onehot: 2^WIDTH output with bit sel set.
module CC_Decoder #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]      sel,
    output logic [(1<<WIDTH)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/cc_rr_search.sv
// Combinational rotating-priority search over a request vector.
// req/start/excl_en/excl in; hit and idx (first set bit from start) out.
module cc_rr_search #(
    parameter int WIDTH = 2
) (
    input  logic [(1<<WIDTH)-1:0] req,
    input  logic [WIDTH-1:0]      start,
    input  logic                  excl_en,
    input  logic [WIDTH-1:0]      excl,
    output logic                  hit,
    output logic [WIDTH-1:0]      idx
);

    logic [WIDTH-1:0] pos;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = '0;
        // pos wraps naturally in WIDTH bits
        for (int i = 0; i < (1<<WIDTH); i++) begin
            pos = start + WIDTH'(i);
            if (!hit && req[pos] && !(excl_en && pos == excl)) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/cc_round_robin_encoder.sv
// Registered round-robin priority encoder holding index/grant until ack.
// clk, reset (async, active-high), bus: slave side of the request/grant bundle.
module cc_round_robin_encoder #(
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    cc_round_robin_encoder_if.slave  bus
);

    import cc_basics_pkg::*;

    logic             state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] index_q, index_d;

    logic             srch_excl_en;
    logic [WIDTH-1:0] srch_start;
    logic             srch_hit;
    logic [WIDTH-1:0] srch_idx;

    logic [(1<<WIDTH)-1:0] dec;

    cc_rr_search #(.WIDTH(WIDTH)) u_search (
        .req     (bus.req),
        .start   (srch_start),
        .excl_en (srch_excl_en),
        .excl    (index_q),
        .hit     (srch_hit),
        .idx     (srch_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        index_d      = index_q;
        srch_start   = ptr_q;
        srch_excl_en = 1'b0;

        if (state_q == CC_RR_GRANT) begin
            // Regrant search starts after the current holder and skips it
            srch_start   = index_q + 1'b1;
            srch_excl_en = 1'b1;
            if (bus.ack) begin
                ptr_d = index_q + 1'b1;
                if (srch_hit) begin
                    index_d = srch_idx;
                end else begin
                    state_d = CC_RR_IDLE;
                end
            end else if (!bus.req[index_q]) begin
                // Withdrawal: no same-cycle regrant
                ptr_d   = index_q + 1'b1;
                state_d = CC_RR_IDLE;
            end
        end else begin
            if (srch_hit) begin
                index_d = srch_idx;
                state_d = CC_RR_GRANT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CC_RR_IDLE;
            ptr_q   <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            index_q <= index_d;
        end
    end

    CC_Decoder #(.WIDTH(WIDTH)) u_dec (
        .sel    (index_q),
        .onehot (dec)
    );

    assign bus.valid = state_q;
    assign bus.index = index_q;
    assign bus.grant = dec & {(1<<WIDTH){state_q}};

endmodule
